ifu_prefetch: RTL and testbench
===============================

// Module: ifu_prefetch
// PURPOSE
//  Parametrised instruction fetch unit with a DEPTH-entry prefetch buffer. It issues sequential
//  AXI4-Lite-style reads (single outstanding) from an internal fetch PC and hands buffered
//  {pc, instr, err} entries to decode over a valid/ready handshake. A redirect input (branch,
//  trap, mret) flushes the buffer and discards any in-flight response. Sits between core
//  control/decode and the instruction-side bus arbiter.
// PARAMETERS
//  XLEN       64          address / PC width
//  DLEN       64          bus read-data width (64 only; word picked by addr[2])
//  DEPTH      4           prefetch buffer entries, power of 2, >= 2
//  RESET_PC   'h80000000  fetch PC after reset
// PORTS
//  clk          in   1     clock, all logic on posedge
//  rst          in   1     synchronous reset, active-high
//  fetch_en     in   1     level; 0 = no new AR issued (in-flight read still completes)
//  redir_valid  in   1     one-cycle redirect strobe
//  redir_pc     in   XLEN  redirect target, bit[1:0] ignored (forced 0)
//  instr_valid  out  1     buffer head valid
//  instr_ready  in   1     decode accepts head
//  instr        out  32    head instruction
//  instr_pc     out  XLEN  head PC
//  instr_err    out  1     head fetched with non-OKAY RRESP (only with IFU_ERR_REPORT_EN)
//  ifu_ARVALID  out  1     read address valid
//  ifu_ARREADY  in   1
//  ifu_ARADDR   out  XLEN  = fetch PC, 4-byte aligned
//  ifu_ARPROT   out  3     constant 3'b100 (instruction access) while ARVALID, else 0
//  ifu_RVALID   in   1
//  ifu_RREADY   out  1     high only in RWAIT/DRAIN
//  ifu_RDATA    in   DLEN
//  ifu_RRESP    in   2     2'b00 = OKAY
// BEHAVIOUR
//  Reset: state IDLE, fetch PC = RESET_PC, buffer empty; all outputs 0.
//  Credit: issue allowed iff fetch_en && (count + inflight) < DEPTH; buffer never overflows.
//  FSM: IDLE -> AREQ when credit. AREQ: ARVALID=1, ARADDR stable; AR handshake -> RWAIT.
//   RWAIT: RREADY=1; R handshake -> push entry, fetch PC += 4 (wraps mod 2^XLEN),
//   next AREQ if credit else IDLE. Back-to-back: RWAIT -> AREQ with no IDLE cycle.
//   DRAIN: RREADY=1; R handshake -> response discarded -> AREQ (redirect PC).
//  Word select: instr = addr[2] ? RDATA[63:32] : RDATA[31:0].
//  Redirect (highest priority): same cycle buffer cleared (instr_valid=0 next cycle, head pop
//   that cycle ignored), fetch PC <= redir_pc. IDLE -> AREQ next cycle (redir to ARVALID = 1).
//   AREQ: ARVALID/ARADDR held until handshake (AXI stability), then DRAIN. RWAIT: -> DRAIN,
//   unless RVALID in the same cycle -> response dropped, -> AREQ. DRAIN: second redirect
//   only updates PC.
//  Latency: R handshake -> instr_valid next cycle (no bypass). Buffer is a registered FIFO;
//   simultaneous push and pop allowed at any count, count unchanged.
//  Empty: instr_valid=0, instr/instr_pc/instr_err hold last value. Full: no AR issued.
//  fetch_en drop: current transaction completes; no new AR; buffer retained.
//  Reset mid-transaction: FSM returns to IDLE; a later stray R beat is ignored (RREADY=0).
// CONFIGURATION
//  IFU_ERR_REPORT_EN defined: non-OKAY RRESP pushes an entry with err=1 (instr=0); fetch
//   then stops (IDLE, no credit) until redirect. Undefined: non-OKAY response is dropped and
//   the same PC re-requested (AREQ); instr_err tied 0.
// STRUCTURE
//  Package ifu_pkg: FSM state localparams (IDLE, AREQ, RWAIT, DRAIN), RESP_OKAY=2'b00,
//   PROT_INSN=3'b100, entry width helper (XLEN+32+1).
//  Sub-module ifu_fifo #(WIDTH, DEPTH): sync FIFO with push/pop/flush, count output,
//   ptr wrap via log2(DEPTH)+1-bit pointers. Top holds FSM, PC, credit, word select.
// TESTING
//  1 Reset, fetch_en=1, ARREADY=RVALID=1 always, instr_ready=1 -> ARADDR 0x80000000,
//    0x80000004, ...; instr_pc follows; one instr per 2 cycles.
//  2 instr_ready=0, DEPTH=4 -> exactly 4 ARs, then ARVALID low; count=4; ready=1 resumes.
//  3 Redirect to 0x80001000 while in RWAIT -> old response dropped (RREADY high),
//    next ARADDR=0x80001000, buffer empty next cycle.
//  4 Redirect during AREQ with ARREADY=0 for 3 cycles -> ARADDR held old value until
//    handshake, DRAIN, then AR at target.
//  5 RDATA=0x00000013_00100073 at 0x80000004 -> instr=0x00000013; at 0x80000000 ->
//    0x00100073.
//  6 RRESP=2'b10 at 0x80000008 -> with IFU_ERR_REPORT_EN: entry err=1, no further AR until
//    redirect; without: AR to 0x80000008 reissued, instr_err stays 0.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: FSM states, AXI-Lite constants and buffer entry width for the instruction prefetcher
package ifu_pkg;
  typedef enum logic [1:0] {IDLE, AREQ, RWAIT, DRAIN} ifu_state_t;
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [2:0] PROT_INSN = 3'b100;
  function automatic int entry_w(input int xlen);
    return xlen + 32 + 1;
  endfunction
endpackage

// File: rtl/ifu_fifo.sv
// ifu_fifo: registered sync FIFO with flush and count; head output holds its last value while empty
module ifu_fifo #(
  parameter int WIDTH = 97,
  parameter int DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic                    flush,
  input  logic [WIDTH-1:0]        din,
  output logic [WIDTH-1:0]        dout,
  output logic [$clog2(DEPTH):0]  count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic [WIDTH-1:0] r_last;
  logic             w_empty;
  assign w_empty = r_wr == r_rd;
  assign count   = r_wr - r_rd;
  assign dout    = w_empty ? r_last : r_mem[r_rd[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !flush) r_mem[r_wr[AW-1:0]] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      r_wr   <= '0;
      r_rd   <= '0;
      r_last <= '0;
    end else begin
      r_last <= dout;
      r_wr   <= flush ? r_rd : r_wr + (AW+1)'(push);
      r_rd   <= r_rd + (AW+1)'(pop && !flush && !w_empty);
    end
endmodule

// File: rtl/ifu_prefetch.sv
// ifu_prefetch: single-outstanding sequential instruction prefetcher; IFU_ERR_REPORT_EN buffers bus errors instead of retrying
module ifu_prefetch
  import ifu_pkg::*;
#(
  parameter int              XLEN     = 64,
  parameter int              DLEN     = 64,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = 'h80000000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  input  logic            redir_valid,
  input  logic [XLEN-1:0] redir_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic            instr_err,
  output logic            ifu_ARVALID,
  input  logic            ifu_ARREADY,
  output logic [XLEN-1:0] ifu_ARADDR,
  output logic [2:0]      ifu_ARPROT,
  input  logic            ifu_RVALID,
  output logic            ifu_RREADY,
  input  logic [DLEN-1:0] ifu_RDATA,
  input  logic [1:0]      ifu_RRESP
);
  localparam int EW = entry_w(XLEN);
  localparam int AW = $clog2(DEPTH);
  localparam logic [XLEN-1:0] ALIGN = ~XLEN'(3);
`ifdef IFU_ERR_REPORT_EN
  localparam bit ERR_REPORT = 1'b1;
`else
  localparam bit ERR_REPORT = 1'b0;
`endif
  ifu_state_t      r_state;
  ifu_state_t      w_state_nx;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] w_pc_nx;
  logic            r_kill;
  logic            r_stop;
  logic            w_ok;
  logic            w_push;
  logic            w_credit;
  logic [AW:0]     w_count;
  logic [31:0]     w_word;
  logic [EW-1:0]   w_din;
  logic [EW-1:0]   w_dout;
  assign w_ok     = ifu_RRESP == RESP_OKAY;
  assign w_word   = r_addr[2] ? ifu_RDATA[63:32] : ifu_RDATA[31:0];
  assign w_push   = r_state == RWAIT && ifu_RVALID && !redir_valid && (w_ok || ERR_REPORT);
  assign w_din    = {r_addr, w_ok ? w_word : 32'h0, !w_ok};
  assign w_credit = fetch_en && !r_stop && (int'(w_count) + (r_state == RWAIT ? 1 : 0)) < DEPTH;
  assign w_pc_nx  = redir_valid ? (redir_pc & ALIGN) : (w_push && w_ok) ? r_pc + XLEN'(4) : r_pc;
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    w_state_nx = (redir_valid || w_credit) ? AREQ : IDLE;
      AREQ:    w_state_nx = !ifu_ARREADY ? AREQ : (redir_valid || r_kill) ? DRAIN : RWAIT;
      RWAIT:   w_state_nx = !ifu_RVALID ? (redir_valid ? DRAIN : RWAIT) :
                            redir_valid ? AREQ :
                            !w_ok ? (ERR_REPORT ? IDLE : AREQ) :
                            w_credit ? AREQ : IDLE;
      default: w_state_nx = ifu_RVALID ? AREQ : DRAIN;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC & ALIGN;
      r_addr  <= '0;
      r_kill  <= 1'b0;
      r_stop  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_pc    <= w_pc_nx;
      r_addr  <= (w_state_nx == AREQ && r_state != AREQ) ? w_pc_nx : r_addr;
      r_kill  <= r_state == AREQ && !ifu_ARREADY && (redir_valid || r_kill);
      r_stop  <= redir_valid ? 1'b0 : (w_push && !w_ok) ? 1'b1 : r_stop;
    end
  ifu_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (instr_valid && instr_ready),
    .flush (redir_valid),
    .din   (w_din),
    .dout  (w_dout),
    .count (w_count)
  );
  assign instr_valid               = w_count != '0;
  assign {instr_pc, instr, instr_err} = w_dout;
  assign ifu_ARVALID               = r_state == AREQ;
  assign ifu_ARADDR                = r_addr;
  assign ifu_ARPROT                = ifu_ARVALID ? PROT_INSN : 3'b000;
  assign ifu_RREADY                = r_state == RWAIT || r_state == DRAIN;
endmodule

// File: tb/tb_ifu_prefetch.sv
// tb_ifu_prefetch: directed scoreboard bench for ifu_prefetch (IFU_ERR_REPORT_EN selects the error-report expectations)
module tb_ifu_prefetch;
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] ins;
    logic        err;
  } ent_t;
  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        redir_valid;
  logic [63:0] redir_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;
  logic        instr_err;
  logic        ifu_ARVALID;
  logic        ifu_ARREADY;
  logic [63:0] ifu_ARADDR;
  logic [2:0]  ifu_ARPROT;
  logic        ifu_RVALID;
  logic        ifu_RREADY;
  logic [63:0] ifu_RDATA;
  logic [1:0]  ifu_RRESP;
  ent_t        q[$];
  int          checks = 0;
  int          errors = 0;
  logic [63:0] mpc;
  logic [63:0] cur_ar;
  logic [63:0] pend_addr;
  logic [63:0] err_addr;
  bit          ar_active;
  bit          ar_kill;
  bit          pend_v;
  bit          pend_kill;
  bit          ar_en;
  bit          r_en;
  bit          ovr_en;
  int          ar_cnt;
  int          ar8_cnt;
  int          n;
  always #5 clk = ~clk;
  ifu_prefetch dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .redir_valid (redir_valid),
    .redir_pc    (redir_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_err   (instr_err),
    .ifu_ARVALID (ifu_ARVALID),
    .ifu_ARREADY (ifu_ARREADY),
    .ifu_ARADDR  (ifu_ARADDR),
    .ifu_ARPROT  (ifu_ARPROT),
    .ifu_RVALID  (ifu_RVALID),
    .ifu_RREADY  (ifu_RREADY),
    .ifu_RDATA   (ifu_RDATA),
    .ifu_RRESP   (ifu_RRESP)
  );
  function automatic logic [31:0] f(input logic [63:0] a);
    return a[31:0] ^ 32'h1357_9BDF;
  endfunction
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    logic [63:0] base;
    ent_t        e;
    base        = pend_addr & ~64'h7;
    ifu_ARREADY = ar_en;
    ifu_RVALID  = pend_v && r_en;
    ifu_RDATA   = ovr_en ? 64'h00000013_00100073 : {f(base + 64'h4), f(base)};
    ifu_RRESP   = (pend_v && pend_addr == err_addr) ? 2'b10 : 2'b00;
    if (ifu_ARVALID) begin
      if (!ar_active) begin
        ar_active = 1'b1;
        cur_ar    = mpc;
      end
      chk("araddr", ifu_ARADDR, cur_ar);
      chk("arprot", ifu_ARPROT, 3'b100);
    end
    if (instr_valid && instr_ready && !redir_valid) begin
      if (q.size() == 0) chk("instr_valid_unexpected", instr_valid, 0);
      else begin
        e = q.pop_front();
        chk("head", {instr_pc, instr, instr_err}, e);
      end
    end
    if (ifu_RREADY && ifu_RVALID) begin
      if (!pend_kill && !redir_valid) begin
        if (ifu_RRESP == 2'b00) begin
          e.pc  = pend_addr;
          e.ins = ovr_en ? (pend_addr[2] ? 32'h00000013 : 32'h00100073) : f(pend_addr);
          e.err = 1'b0;
          q.push_back(e);
          mpc = mpc + 64'h4;
        end else begin
`ifdef IFU_ERR_REPORT_EN
          e.pc  = pend_addr;
          e.ins = 32'h0;
          e.err = 1'b1;
          q.push_back(e);
`endif
          err_addr = '1;
        end
      end
      pend_v = 1'b0;
    end
    if (ifu_ARVALID && ifu_ARREADY) begin
      pend_v    = 1'b1;
      pend_addr = cur_ar;
      pend_kill = ar_kill;
      ar_kill   = 1'b0;
      ar_active = 1'b0;
      ar_cnt++;
      if (cur_ar == 64'h80000008) ar8_cnt++;
    end
    if (redir_valid) begin
      q.delete();
      mpc = redir_pc & ~64'h3;
      if (pend_v) pend_kill = 1'b1;
      if (ar_active) ar_kill = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic redirect(input logic [63:0] pc);
    redir_valid = 1'b1;
    redir_pc    = pc;
    cyc();
    redir_valid = 1'b0;
  endtask
  initial begin
    rst = 1'b1; fetch_en = 1'b0; redir_valid = 1'b0; redir_pc = '0; instr_ready = 1'b0;
    ifu_ARREADY = 1'b0; ifu_RVALID = 1'b0; ifu_RDATA = '0; ifu_RRESP = 2'b00;
    ar_en = 1'b1; r_en = 1'b1; ovr_en = 1'b0; err_addr = '1; mpc = 64'h80000000;
    cur_ar = '0; pend_addr = '0; ar_active = 1'b0; ar_kill = 1'b0; pend_v = 1'b0; pend_kill = 1'b0;
    ar_cnt = 0; ar8_cnt = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_arvalid", ifu_ARVALID, 0);
    chk("rst_rready", ifu_RREADY, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_araddr", ifu_ARADDR, 0);
    chk("rst_arprot", ifu_ARPROT, 0);
    chk("rst_instr", instr, 0);
    chk("rst_pc", instr_pc, 0);
    chk("rst_err", instr_err, 0);
    fetch_en = 1'b1; instr_ready = 1'b1;
    repeat (12) cyc();
    chk("t1_ar_rate", ar_cnt, 6);
    fetch_en = 1'b0;
    repeat (6) cyc();
    chk("fe_off_arvalid", ifu_ARVALID, 0);
    chk("fe_off_drained", instr_valid, 0);
    n = ar_cnt;
    repeat (4) cyc();
    chk("fe_off_no_ar", ar_cnt - n, 0);
    instr_ready = 1'b0; fetch_en = 1'b1; n = ar_cnt;
    repeat (20) cyc();
    chk("t2_ars", ar_cnt - n, 4);
    chk("t2_arvalid_low", ifu_ARVALID, 0);
    chk("t2_valid", instr_valid, 1);
    chk("t2_buffered", q.size(), 4);
    instr_ready = 1'b1;
    repeat (16) cyc();
    chk("t2_resumed", (ar_cnt - n) > 4, 1);
    instr_ready = 1'b0;
    repeat (4) cyc();
    r_en = 1'b0;
    for (int i = 0; i < 20 && ifu_RREADY !== 1'b1; i++) cyc();
    chk("t3_rwait", ifu_RREADY, 1);
    chk("t3_pre_valid", instr_valid, 1);
    redirect(64'h80001000);
    chk("t3_flush", instr_valid, 0);
    chk("t3_drain_rready", ifu_RREADY, 1);
    chk("t3_no_ar", ifu_ARVALID, 0);
    r_en = 1'b1; instr_ready = 1'b1;
    cyc();
    chk("t3_ar", ifu_ARVALID, 1);
    chk("t3_araddr", ifu_ARADDR, 64'h80001000);
    repeat (6) cyc();
    ar_en = 1'b0;
    for (int i = 0; i < 20 && ifu_ARVALID !== 1'b1; i++) cyc();
    chk("t4_areq", ifu_ARVALID, 1);
    redirect(64'h80002000);
    repeat (2) cyc();
    chk("t4_hold", ifu_ARADDR, cur_ar);
    chk("t4_hold_old", ifu_ARADDR != 64'h80002000, 1);
    ar_en = 1'b1;
    cyc();
    chk("t4_drain_rready", ifu_RREADY, 1);
    cyc();
    chk("t4_dropped", instr_valid, 0);
    chk("t4_ar", ifu_ARVALID, 1);
    chk("t4_araddr", ifu_ARADDR, 64'h80002000);
    repeat (4) cyc();
    ovr_en = 1'b1;
    redirect(64'h80000000);
    repeat (8) cyc();
    ovr_en = 1'b0;
    err_addr = 64'h80000008; ar8_cnt = 0;
    redirect(64'h80000000);
    repeat (14) cyc();
`ifdef IFU_ERR_REPORT_EN
    chk("t6_ar8_once", ar8_cnt, 1);
    n = ar_cnt;
    repeat (6) cyc();
    chk("t6_stopped", ar_cnt - n, 0);
    chk("t6_arvalid_low", ifu_ARVALID, 0);
    redirect(64'h80000100);
    chk("t6_resume", ifu_ARVALID, 1);
    repeat (6) cyc();
`else
    chk("t6_retry", ar8_cnt, 2);
    chk("t6_err_low", instr_err, 0);
`endif
    fetch_en = 1'b0;
    repeat (10) cyc();
    chk("final_empty", instr_valid, 0);
    chk("final_sb_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
